// File: rtl/ftdi_seq_pkg.sv
// Shared FSM states, opcodes and helpers for the FTDI command sequencer.
package ftdi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OP_REL,
    ARG_WAIT,
    ARG_REL,
    EXEC,
    TX_REQ,
    TX_REL
  } state_t;

  localparam logic [7:0] OPC_INV  = 8'hAA;
  localparam logic [7:0] OPC_ECHO = 8'h55;
  localparam logic [7:0] OPC_WR   = 8'h01;
  localparam logic [7:0] OPC_RD   = 8'h02;
  localparam logic [7:0] RESP_OK  = 8'h00;

  // Error counter increments stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ftdi_hs_sync.sv
// Multi-bit two-flop synchronizer for independent handshake levels; adds 2 cycles per edge.
module ftdi_hs_sync #(
  parameter int WIDTH = 1
) (
  input  logic             in_clk,
  input  logic             in_reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ftdi_cmd_sequencer.sv
// Two-byte command / one-byte response engine on four-phase RX and TX handshakes.
// Define FTDI_SEQ_SYNC_EN to pass in_rx_prd_rdy/in_tx_ack through two-flop synchronizers.
module ftdi_cmd_sequencer
  import ftdi_seq_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] LED_RESET      = 8'h00,
  parameter logic [7:0] ERR_RESP       = 8'hEE
) (
  input  logic       in_clk,
  input  logic       in_reset_n,
  input  logic       in_rx_prd_rdy,
  input  logic [7:0] in_rx_data,
  output logic       out_rx_cons_rdy,
  output logic       out_rx_ena,
  output logic       out_tx_data_rdy,
  output logic [7:0] out_tx_data,
  input  logic       in_tx_ack,
  output logic [7:0] out_led_reg,
  output logic [7:0] out_err_cnt
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic rx_req;
  logic tx_ack;

`ifdef FTDI_SEQ_SYNC_EN
  logic [1:0] hs_q;

  ftdi_hs_sync #(.WIDTH(2)) u_hs_sync (
    .in_clk     (in_clk),
    .in_reset_n (in_reset_n),
    .d          ({in_tx_ack, in_rx_prd_rdy}),
    .q          (hs_q)
  );

  assign rx_req = hs_q[0];
  assign tx_ack = hs_q[1];
`else
  assign rx_req = in_rx_prd_rdy;
  assign tx_ack = in_tx_ack;
`endif

  state_t        state;
  logic [7:0]    opcode;
  logic [7:0]    operand;
  logic [TW-1:0] timer;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state           <= IDLE;
      opcode          <= '0;
      operand         <= '0;
      timer           <= '0;
      out_rx_cons_rdy <= 1'b0;
      out_rx_ena      <= 1'b1;
      out_tx_data_rdy <= 1'b0;
      out_tx_data     <= '0;
      out_led_reg     <= LED_RESET;
      out_err_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_req) begin
            opcode          <= in_rx_data;
            out_rx_cons_rdy <= 1'b1;
            state           <= OP_REL;
          end
        end
        OP_REL: begin
          if (!rx_req) begin
            out_rx_cons_rdy <= 1'b0;
            timer           <= '0;
            state           <= ARG_WAIT;
          end
        end
        ARG_WAIT: begin
          // An operand arriving on the final timer cycle still counts.
          if (rx_req) begin
            operand         <= in_rx_data;
            out_rx_cons_rdy <= 1'b1;
            state           <= ARG_REL;
          end else if (timer == T_LAST) begin
            out_err_cnt <= sat_inc(out_err_cnt);
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ARG_REL: begin
          if (!rx_req) begin
            out_rx_cons_rdy <= 1'b0;
            out_rx_ena      <= 1'b0;
            state           <= EXEC;
          end
        end
        EXEC: begin
          case (opcode)
            OPC_INV:  out_tx_data <= ~operand;
            OPC_ECHO: out_tx_data <= operand;
            OPC_WR: begin
              out_led_reg <= operand;
              out_tx_data <= RESP_OK;
            end
            OPC_RD:   out_tx_data <= out_led_reg;
            default: begin
              out_tx_data <= ERR_RESP;
              out_err_cnt <= sat_inc(out_err_cnt);
            end
          endcase
          state <= TX_REQ;
        end
        TX_REQ: begin
          // Ack only counts once our request is actually visible.
          if (out_tx_data_rdy && tx_ack) begin
            out_tx_data_rdy <= 1'b0;
            state           <= TX_REL;
          end else begin
            out_tx_data_rdy <= 1'b1;
          end
        end
        TX_REL: begin
          if (!tx_ack) begin
            out_rx_ena <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_cmd_sequencer.sv
// Directed scoreboard bench for ftdi_cmd_sequencer (default build, TIMEOUT_CYCLES=16).
module tb_ftdi_cmd_sequencer;

  logic       in_clk = 1'b0;
  logic       in_reset_n = 1'b0;
  logic       in_rx_prd_rdy = 1'b0;
  logic [7:0] in_rx_data = 8'h00;
  logic       in_tx_ack = 1'b0;
  logic       out_rx_cons_rdy;
  logic       out_rx_ena;
  logic       out_tx_data_rdy;
  logic [7:0] out_tx_data;
  logic [7:0] out_led_reg;
  logic [7:0] out_err_cnt;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic prev_rdy = 1'b0;
  logic [7:0] sb[$];
  logic [7:0] exp_err = 8'h00;

  ftdi_cmd_sequencer #(
    .TIMEOUT_CYCLES (16),
    .LED_RESET      (8'h00),
    .ERR_RESP       (8'hEE)
  ) dut (
    .in_clk          (in_clk),
    .in_reset_n      (in_reset_n),
    .in_rx_prd_rdy   (in_rx_prd_rdy),
    .in_rx_data      (in_rx_data),
    .out_rx_cons_rdy (out_rx_cons_rdy),
    .out_rx_ena      (out_rx_ena),
    .out_tx_data_rdy (out_tx_data_rdy),
    .out_tx_data     (out_tx_data),
    .in_tx_ack       (in_tx_ack),
    .out_led_reg     (out_led_reg),
    .out_err_cnt     (out_err_cnt)
  );

  always #5 in_clk = ~in_clk;

  always @(negedge in_clk) begin
    if (out_tx_data_rdy && !prev_rdy) pulses++;
    prev_rdy = out_tx_data_rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge in_clk);
    in_rx_data    = b;
    in_rx_prd_rdy = 1'b1;
    n = 0;
    while (!out_rx_cons_rdy && n < 50) begin @(negedge in_clk); n++; end
    check("rx_ack_rise", {31'd0, out_rx_cons_rdy}, 1);
    in_rx_prd_rdy = 1'b0;
    n = 0;
    while (out_rx_cons_rdy && n < 50) begin @(negedge in_clk); n++; end
    check("rx_ack_fall", {31'd0, out_rx_cons_rdy}, 0);
  endtask

  task automatic get_resp(input int ack_delay);
    int n;
    logic [7:0] exp;
    n = 0;
    while (!out_tx_data_rdy && n < 50) begin @(negedge in_clk); n++; end
    check("tx_req_rise", {31'd0, out_tx_data_rdy}, 1);
    check("rx_ena_low", {31'd0, out_rx_ena}, 0);
    check("sb_nonempty", {31'd0, sb.size() != 0}, 1);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    check("tx_data", {24'd0, out_tx_data}, {24'd0, exp});
    repeat (ack_delay) @(negedge in_clk);
    if (ack_delay > 0) check("tx_req_held", {31'd0, out_tx_data_rdy}, 1);
    in_tx_ack = 1'b1;
    n = 0;
    while (out_tx_data_rdy && n < 50) begin @(negedge in_clk); n++; end
    check("tx_req_fall", {31'd0, out_tx_data_rdy}, 0);
    in_tx_ack = 1'b0;
    n = 0;
    while (!out_rx_ena && n < 50) begin @(negedge in_clk); n++; end
    check("rx_ena_back", {31'd0, out_rx_ena}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cons"},  {31'd0, out_rx_cons_rdy}, 0);
    check({tag, "_ena"},   {31'd0, out_rx_ena}, 1);
    check({tag, "_txrdy"}, {31'd0, out_tx_data_rdy}, 0);
    check({tag, "_txdat"}, {24'd0, out_tx_data}, 0);
    check({tag, "_led"},   {24'd0, out_led_reg}, 0);
    check({tag, "_err"},   {24'd0, out_err_cnt}, 0);
  endtask

  initial begin
    int n;

    // Reset values
    repeat (3) @(negedge in_clk);
    check_reset_outputs("rst");
    in_reset_n = 1'b1;
    @(negedge in_clk);
    check_reset_outputs("post_rst");

    // Invert, with latency measured from operand release
    sb.push_back(8'hC3);
    exp_pulses++;
    send_byte(8'hAA);
    send_byte(8'h3C);
    n = 0;
    while (!out_tx_data_rdy && n < 50) begin @(posedge in_clk); n++; @(negedge in_clk); end
    check("resp_latency", n, 2);
    get_resp(3);
    repeat (4) @(negedge in_clk);
    check("one_pulse", pulses, exp_pulses);

    // Write LED then read it back
    sb.push_back(8'h00);
    exp_pulses++;
    send_byte(8'h01);
    send_byte(8'h5A);
    get_resp(1);
    check("led_after_wr", {24'd0, out_led_reg}, 32'h5A);
    sb.push_back(8'h5A);
    exp_pulses++;
    send_byte(8'h02);
    send_byte(8'h00);
    get_resp(0);
    check("led_after_rd", {24'd0, out_led_reg}, 32'h5A);

    // Unknown opcode
    sb.push_back(8'hEE);
    exp_pulses++;
    exp_err = exp_err + 8'd1;
    send_byte(8'h7F);
    send_byte(8'h11);
    get_resp(2);
    check("err_bad_op", {24'd0, out_err_cnt}, {24'd0, exp_err});

    // Operand timeout: abort 16 cycles into the wait, no response
    send_byte(8'h55);
    n = 0;
    while (out_err_cnt == exp_err && n < 40) begin @(posedge in_clk); n++; @(negedge in_clk); end
    exp_err = exp_err + 8'd1;
    check("timeout_cycles", n, 16);
    check("err_timeout", {24'd0, out_err_cnt}, {24'd0, exp_err});
    check("timeout_rx_ena", {31'd0, out_rx_ena}, 1);
    repeat (5) @(negedge in_clk);
    check("timeout_no_tx", pulses, exp_pulses);
    sb.push_back(8'h22);
    exp_pulses++;
    send_byte(8'h55);
    send_byte(8'h22);
    get_resp(1);
    check("pulses_after_echo", pulses, exp_pulses);

    // Reset while a response is pending
    exp_pulses++;
    send_byte(8'h55);
    send_byte(8'h77);
    n = 0;
    while (!out_tx_data_rdy && n < 50) begin @(negedge in_clk); n++; end
    check("pre_rst_req", {31'd0, out_tx_data_rdy}, 1);
    in_reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge in_clk);
    in_reset_n = 1'b1;
    repeat (5) @(negedge in_clk);
    check("no_resp_after_rst", pulses, exp_pulses);
    check("idle_after_rst", {31'd0, out_rx_ena}, 1);
    exp_err = 8'h00;

    // Error counter saturation
    for (int i = 0; i < 256; i++) begin
      sb.push_back(8'hEE);
      exp_pulses++;
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      send_byte(8'hF0);
      send_byte(i[7:0]);
      get_resp(0);
      if (i == 254) check("err_at_255", {24'd0, out_err_cnt}, {24'd0, exp_err});
    end
    check("err_saturated", {24'd0, out_err_cnt}, 32'hFF);
    check("final_pulses", pulses, exp_pulses);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
